// File: rtl/tetris_ctrl.sv
// Command initiator for the tetris engine: button edges, auto-repeat and gravity
// become single-cycle ctrl commands, with at most one command outstanding.
package tetris_pkg;
  typedef enum logic [3:0] {
    NONE, INIT, WAIT, GEN, CLEAR, LEFT, RIGHT, DOWN,
    ROTATE, ROTATE_REV, DROP, HOLD, END
  } state_type;
endpackage

module tetris_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned GRAVITY_BASE  = 50_000_000,
  parameter int unsigned GRAVITY_STEP  = 4_000_000,
  parameter int unsigned GRAVITY_MIN   = 5_000_000,
  parameter int unsigned REPEAT_DELAY  = 20_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_rotate,
  input  logic        btn_rotate_rev,
  input  logic        btn_drop,
  input  logic        btn_hold,
  input  logic        btn_start,
  input  state_type   state,
  input  logic [15:0] score,
  output state_type   ctrl,
  output logic [3:0]  level
);
  localparam int B_LEFT = 0, B_RIGHT = 1, B_DOWN = 2, B_ROT = 3;
  localparam int B_ROTREV = 4, B_DROP = 5, B_HOLD = 6, B_START = 7;

  typedef enum logic {IDLE, BUSY} fsm_t;

  logic [7:0]  btn, btn_q, btn_rise, pend_q, pend_nxt, pend_clr;
  logic        armed;
  logic [31:0] rpt_cnt [3];
  logic [2:0]  rpt_fire;
  logic [31:0] grav_cnt, lvl_step, period, period_m1;
  logic        grav_pend, grav_hit, grav_clr, in_menu;
  fsm_t        fsm_q, fsm_nxt;
  state_type   ctrl_nxt;

  assign btn = {btn_start, btn_hold, btn_drop, btn_rotate_rev,
                btn_rotate, btn_down, btn_right, btn_left};
  // armed masks the first cycle after reset so buttons held through reset need a fresh press
  assign btn_rise = armed ? (btn & ~btn_q) : 8'h00;
  assign in_menu  = (state == INIT) || (state == END);

  // Repeat counters: 0 = idle, terminal count at 1 re-arms the pending bit
  always_comb begin
    for (int i = 0; i < 3; i++)
      rpt_fire[i] = btn[i] && !btn_rise[i] && (rpt_cnt[i] == 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_q <= '0;
      armed <= 1'b0;
      for (int i = 0; i < 3; i++) rpt_cnt[i] <= '0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!btn[i])                  rpt_cnt[i] <= '0;
        else if (btn_rise[i])         rpt_cnt[i] <= REPEAT_DELAY;
        else if (rpt_cnt[i] == 32'd1) rpt_cnt[i] <= REPEAT_PERIOD;
        else if (rpt_cnt[i] != '0)    rpt_cnt[i] <= rpt_cnt[i] - 32'd1;
      end
    end
  end

  always_comb begin
    lvl_step = 32'(level) * GRAVITY_STEP;
    if (lvl_step >= GRAVITY_BASE)                    period = GRAVITY_MIN;
    else if ((GRAVITY_BASE - lvl_step) < GRAVITY_MIN) period = GRAVITY_MIN;
    else                                             period = GRAVITY_BASE - lvl_step;
    period_m1 = period - 32'd1;
  end
  assign grav_hit = (grav_cnt == period_m1);

  always_comb begin
    fsm_nxt  = fsm_q;
    ctrl_nxt = NONE;
    pend_clr = '0;
    grav_clr = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (in_menu) begin
          if (pend_q[B_START]) begin
            ctrl_nxt = DROP;  pend_clr[B_START] = 1'b1;  fsm_nxt = BUSY;
          end
        end else if (state == WAIT) begin
          fsm_nxt = BUSY;
          if (pend_q[B_HOLD])        begin ctrl_nxt = HOLD;       pend_clr[B_HOLD]   = 1'b1; end
          else if (pend_q[B_DROP])   begin ctrl_nxt = DROP;       pend_clr[B_DROP]   = 1'b1; end
          else if (pend_q[B_ROT])    begin ctrl_nxt = ROTATE;     pend_clr[B_ROT]    = 1'b1; end
          else if (pend_q[B_ROTREV]) begin ctrl_nxt = ROTATE_REV; pend_clr[B_ROTREV] = 1'b1; end
          else if (pend_q[B_LEFT])   begin ctrl_nxt = LEFT;       pend_clr[B_LEFT]   = 1'b1; end
          else if (pend_q[B_RIGHT])  begin ctrl_nxt = RIGHT;      pend_clr[B_RIGHT]  = 1'b1; end
          else if (pend_q[B_DOWN] || grav_pend) begin
            ctrl_nxt = DOWN;  pend_clr[B_DOWN] = 1'b1;  grav_clr = 1'b1;
          end
          else fsm_nxt = IDLE;
        end
      end
      BUSY: if (state != WAIT) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // A new edge beats the clear-on-issue of the same bit
  always_comb begin
    pend_nxt = (pend_q & ~pend_clr) | btn_rise | {5'b00000, rpt_fire};
    if (in_menu) pend_nxt[6:0] = '0;
    else         pend_nxt[B_START] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q  <= IDLE;
      ctrl   <= NONE;
      pend_q <= '0;
      level  <= '0;
    end else begin
      fsm_q  <= fsm_nxt;
      ctrl   <= ctrl_nxt;
      pend_q <= pend_nxt;
      level  <= (score[15:8] != 8'h00) ? 4'd10 : score[7:4];
    end
  end

  // Issue clears gravity even if the counter is still parked at period-1
  always_ff @(posedge clk) begin
    if (!reset_n || in_menu) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else begin
      grav_pend <= grav_clr ? 1'b0 : (grav_pend | grav_hit);
      if (grav_clr || (state == GEN)) grav_cnt <= '0;
      else if (!grav_hit)             grav_cnt <= grav_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_tetris_ctrl.sv
// Scoreboard bench for tetris_ctrl: a small engine model accepts each command
// for 3 cycles; expected commands and their cycles are queued at stimulus time.
module tb_tetris_ctrl;
  import tetris_pkg::*;

  localparam int GB = 100, GS = 8, GM = 20, RD = 20, RP = 5;
  // ctrl at y -> engine busy y+1..y+3 -> WAIT decision at y+4 -> next ctrl at y+5
  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  btns = '0;
  logic [15:0] score = '0;
  logic [3:0]  level;
  state_type   state, ctrl;
  state_type   base_state = WAIT, eng_cmd = NONE, acc_cmd = NONE, prev_ctrl = NONE;
  int          eng_cnt = 0;
  bit          acc_pend = 1'b0;
  int          cyc = 0, n_assert = 0, n_fail = 0;
  int          t0, w, per;
  logic [15:0] gscore [3] = '{16'h0003, 16'h0050, 16'h0120};

  typedef struct { state_type cmd; int at; } exp_t;
  exp_t sb[$];

  tetris_ctrl #(
    .GRAVITY_BASE(GB), .GRAVITY_STEP(GS), .GRAVITY_MIN(GM),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_left(btns[0]), .btn_right(btns[1]), .btn_down(btns[2]),
    .btn_rotate(btns[3]), .btn_rotate_rev(btns[4]), .btn_drop(btns[5]),
    .btn_hold(btns[6]), .btn_start(btns[7]),
    .state(state), .score(score), .ctrl(ctrl), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign state = (eng_cnt != 0) ? eng_cmd : base_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cmd(input state_type c, input int at);
    sb.push_back('{cmd: c, at: at});
  endtask

  function automatic int exp_level(input logic [15:0] s);
    if (s[15:8] != 8'h00) return 10;
    return int'(s[7:4]);
  endfunction

  function automatic int exp_period(input int lvl);
    int p;
    p = GB - lvl * GS;
    return (p < GM) ? GM : p;
  endfunction

  // Engine: sees ctrl in cycle y, sits in the commanded state for y+1..y+3
  always @(negedge clk) begin
    if (eng_cnt != 0) eng_cnt = eng_cnt - 1;
    if (acc_pend) begin
      eng_cmd  = acc_cmd;
      eng_cnt  = 3;
      acc_pend = 1'b0;
    end
    if (ctrl != NONE) begin
      acc_pend = 1'b1;
      acc_cmd  = ctrl;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ctrl != NONE) begin
      check("ctrl_gap", prev_ctrl, NONE);
      if (sb.size() == 0) check("ctrl_unexpected", ctrl, NONE);
      else begin
        e = sb.pop_front();
        check("ctrl_cmd", ctrl, e.cmd);
        check("ctrl_cycle", cyc, e.at);
      end
    end
    prev_ctrl = ctrl;
  end

  initial begin
    // Reset with every button held: nothing may fire afterwards
    btns = 8'hFF; score = 16'h0050; base_state = WAIT;
    tick(2);
    check("reset_ctrl", ctrl, NONE);
    check("reset_level", level, 0);
    reset_n = 1'b1;
    tick(12);
    check("level_5", level, exp_level(score));
    btns = '0; tick(3);
    base_state = INIT; score = '0; tick(3);

    // Single tap, then a second press while busy
    base_state = WAIT; tick(2);
    t0 = cyc; btns[0] = 1'b1;
    expect_cmd(LEFT, t0 + 2);
    tick(1);
    btns[0] = 1'b0; btns[1] = 1'b1;
    expect_cmd(RIGHT, t0 + 2 + GAP);
    tick(1); btns[1] = 1'b0;
    tick(14); base_state = INIT; tick(3);

    // Simultaneous presses drain in priority order
    base_state = WAIT; tick(2);
    t0 = cyc; btns = 8'b0110_0001;
    expect_cmd(HOLD, t0 + 2);
    expect_cmd(DROP, t0 + 2 + GAP);
    expect_cmd(LEFT, t0 + 2 + 2 * GAP);
    tick(1); btns = '0;
    tick(20); base_state = INIT; tick(3);

    // Auto-repeat while held 40 cycles
    base_state = WAIT; tick(2);
    t0 = cyc; btns[1] = 1'b1;
    expect_cmd(RIGHT, t0 + 2);
    for (int k = 0; k < 4; k++) expect_cmd(RIGHT, t0 + RD + k * RP + 2);
    tick(40); btns[1] = 1'b0;
    tick(10); base_state = INIT; tick(3);

    // Gravity at three levels; counter restarts on the cycle DOWN appears
    for (int i = 0; i < 3; i++) begin
      score = gscore[i]; tick(3);
      check("level", level, exp_level(score));
      per = exp_period(exp_level(score));
      base_state = WAIT; w = cyc;
      for (int k = 1; k <= 3; k++) expect_cmd(DOWN, w + k * (per + 1));
      tick(3 * (per + 1) + 5);
      base_state = INIT; tick(3);
    end
    score = '0; tick(3);

    // END: taps ignored, gravity frozen, start issues DROP only
    base_state = END; tick(2);
    btns[0] = 1'b1; tick(1); btns[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(40);
      check("grav_cnt_end", dut.grav_cnt, 0);
    end
    t0 = cyc; btns[7] = 1'b1;
    expect_cmd(DROP, t0 + 2);
    tick(8);
    check("grav_cnt_end_after", dut.grav_cnt, 0);
    btns[7] = 1'b0;
    base_state = WAIT; tick(15);
    base_state = INIT; tick(3);

    // Reset while a command is about to issue
    base_state = WAIT; tick(2);
    btns[0] = 1'b1; tick(1);
    btns[0] = 1'b0; reset_n = 1'b0; tick(1);
    check("ctrl_after_reset", ctrl, NONE);
    reset_n = 1'b1; tick(12);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
